// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 instruction sequencer.
//   state_t   : sequencer states (unused encodings fall back to StHalted)
//   OP_*      : opcode values of IR[15:12]
//   PCMUX_*, ADDR2_*, ALU_* : datapath mux encodings
//   ctrl_t    : bundle of every control line driven to the datapath
package lc3_pkg;

    typedef enum logic [4:0] {
        StHalted = 5'd0,
        St18,
        St33,
        St35,
        St32,
        St1,
        St5,
        St9,
        St0,
        St22,
        St12,
        St4,
        St21,
        St6,
        St7,
        St25,
        St27,
        St23,
        St16,
        StPause1,
        StPause2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_BUS   = 2'd0;
    localparam logic [1:0] PCMUX_ADDER = 2'd1;
    localparam logic [1:0] PCMUX_INC   = 2'd2;

    localparam logic [1:0] ADDR2_SEXT11 = 2'd0;
    localparam logic [1:0] ADDR2_SEXT9  = 2'd1;
    localparam logic [1:0] ADDR2_SEXT6  = 2'd2;
    localparam logic [1:0] ADDR2_ZERO   = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_AND   = 2'd1;
    localparam logic [1:0] ALU_NOT   = 2'd2;
    localparam logic [1:0] ALU_PASSA = 2'd3;

    typedef struct packed {
        logic       ld_pc;
        logic       ld_led;
        logic       ld_ir;
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic [1:0] addr2mux;
        logic       addr1mux;
        logic [1:0] aluk;
        logic       sr1mux;
        logic       drmux;
        logic       mio_en;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Fixed-latency memory wait counter shared by all memory-access states.
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   clear_i      : force count to zero
//   en_i         : count one cycle of the current access
//   done_o       : current count has reached MEM_WAIT-1
//   done_next_o  : count will be MEM_WAIT-1 after the next edge
module mem_wait_counter #(
    parameter int unsigned MEM_WAIT = 2  // legal range 1..7
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o,
    output logic done_next_o
);

    localparam logic [2:0] Last = 3'(MEM_WAIT - 1);

    logic [2:0] count_q;
    logic [2:0] count_d;

    // Wraps to zero on the final cycle so the next access starts clean.
    always_comb begin
        count_d = count_q;
        if (clear_i || (en_i && done_o)) begin
            count_d = 3'd0;
        end else if (en_i) begin
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o      = (count_q == Last);
    assign done_next_o = (count_d == Last);

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 instruction sequencer: fetch / decode / execute for ADD, AND, NOT, BR,
// JMP, JSR, LDR, STR and PAUSE, driving every datapath control line.
//   Clk, Reset_ah         : clock and asynchronous active-high reset
//   Run, Continue         : start from HALTED / resume from PAUSE
//   IR, BEN               : instruction and branch enable from the datapath
//   LD_*, Gate*           : register loads and bus drivers
//   PCMUX, ADDR2MUX, ADDR1MUX, ALUK, SR1MUX, DRMUX, MIO_EN : mux selects
//   Mem_OE, Mem_WE        : memory read / write strobes
// Outputs are registered from the next state so they are a clean function of
// the current state (and wait count) without a combinational path from inputs.
module lc3_control_fsm
    import lc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset_ah,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        LD_IR,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ALUK,
    output logic        SR1MUX,
    output logic        DRMUX,
    output logic        MIO_EN,
    output logic        Mem_OE,
    output logic        Mem_WE
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;

    logic cnt_en;
    logic cnt_done;
    logic cnt_done_next;

    // Only the opcode field steers the sequencer.
    logic unused_ir;
    assign unused_ir = ^IR[11:0];

    assign cnt_en = (state_q == St33) || (state_q == St25) || (state_q == St16);

    mem_wait_counter #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk_i       (Clk),
        .rst_i       (Reset_ah),
        .clear_i     (!cnt_en),
        .en_i        (cnt_en),
        .done_o      (cnt_done),
        .done_next_o (cnt_done_next)
    );

    // Control word for a state; done only matters in the read-wait states.
    function automatic ctrl_t decode(input state_t s, input logic done);
        ctrl_t c;
        c = '0;
        case (s)
            St18: begin
                c.gate_pc = 1'b1;
                c.ld_mar  = 1'b1;
                c.pcmux   = PCMUX_INC;
                c.ld_pc   = 1'b1;
            end
            St33, St25: begin
                c.mem_oe = 1'b1;
                c.mio_en = 1'b1;
                c.ld_mdr = done;
            end
            St35: begin
                c.gate_mdr = 1'b1;
                c.ld_ir    = 1'b1;
            end
            St32: c.ld_ben = 1'b1;
            St1, St5, St9: begin
                c.sr1mux   = 1'b1;
                c.aluk     = (s == St1) ? ALU_ADD : ((s == St5) ? ALU_AND : ALU_NOT);
                c.gate_alu = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            St22: begin
                c.addr1mux = 1'b1;
                c.addr2mux = ADDR2_SEXT9;
                c.pcmux    = PCMUX_ADDER;
                c.ld_pc    = 1'b1;
            end
            St12: begin
                c.sr1mux   = 1'b1;
                c.aluk     = ALU_PASSA;
                c.gate_alu = 1'b1;
                c.pcmux    = PCMUX_BUS;
                c.ld_pc    = 1'b1;
            end
            St4: begin
                c.gate_pc = 1'b1;
                c.drmux   = 1'b1;
                c.ld_reg  = 1'b1;
            end
            St21: begin
                c.addr1mux = 1'b1;
                c.addr2mux = ADDR2_SEXT11;
                c.pcmux    = PCMUX_ADDER;
                c.ld_pc    = 1'b1;
            end
            St6, St7: begin
                c.sr1mux      = 1'b1;
                c.addr2mux    = ADDR2_SEXT6;
                c.gate_marmux = 1'b1;
                c.ld_mar      = 1'b1;
            end
            St27: begin
                c.gate_mdr = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            St23: begin
                c.aluk     = ALU_PASSA;
                c.gate_alu = 1'b1;
                c.ld_mdr   = 1'b1;
            end
            St16:     c.mem_we = 1'b1;
            StPause1: c.ld_led = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            StHalted: if (Run) state_d = St18;
            St18:     state_d = St33;
            St33:     if (cnt_done) state_d = St35;
            St35:     state_d = St32;
            St32: begin
                case (IR[15:12])
                    OP_ADD:   state_d = St1;
                    OP_AND:   state_d = St5;
                    OP_NOT:   state_d = St9;
                    OP_BR:    state_d = St0;
                    OP_JMP:   state_d = St12;
                    OP_JSR:   state_d = St4;  // JSRR unsupported: always PC-relative
                    OP_LDR:   state_d = St6;
                    OP_STR:   state_d = St7;
                    OP_PAUSE: state_d = StPause1;
                    default:  state_d = St18;  // unsupported opcode runs as NOP
                endcase
            end
            St1, St5, St9, St12, St22, St21, St27: state_d = St18;
            St0:      state_d = BEN ? St22 : St18;
            St4:      state_d = St21;
            St6:      state_d = St25;
            St7:      state_d = St23;
            St25:     if (cnt_done) state_d = St27;
            St23:     state_d = St16;
            St16:     if (cnt_done) state_d = St18;
            // Two-step handshake: one instruction per press/release of Continue.
            StPause1: if (Continue) state_d = StPause2;
            StPause2: if (!Continue) state_d = St18;
            default:  state_d = StHalted;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            state_q <= StHalted;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d, cnt_done_next);
        end
    end

    assign LD_PC      = ctrl_q.ld_pc;
    assign LD_LED     = ctrl_q.ld_led;
    assign LD_IR      = ctrl_q.ld_ir;
    assign LD_MAR     = ctrl_q.ld_mar;
    assign LD_MDR     = ctrl_q.ld_mdr;
    assign LD_BEN     = ctrl_q.ld_ben;
    assign LD_CC      = ctrl_q.ld_cc;
    assign LD_REG     = ctrl_q.ld_reg;
    assign GatePC     = ctrl_q.gate_pc;
    assign GateMDR    = ctrl_q.gate_mdr;
    assign GateALU    = ctrl_q.gate_alu;
    assign GateMARMUX = ctrl_q.gate_marmux;
    assign PCMUX      = ctrl_q.pcmux;
    assign ADDR2MUX   = ctrl_q.addr2mux;
    assign ADDR1MUX   = ctrl_q.addr1mux;
    assign ALUK       = ctrl_q.aluk;
    assign SR1MUX     = ctrl_q.sr1mux;
    assign DRMUX      = ctrl_q.drmux;
    assign MIO_EN     = ctrl_q.mio_en;
    assign Mem_OE     = ctrl_q.mem_oe;
    assign Mem_WE     = ctrl_q.mem_we;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Self-checking bench for lc3_control_fsm. Expected control words come from a
// per-instruction micro-sequence list built from the instruction's semantics.
module tb_lc3_control_fsm;

    localparam int unsigned MW = 2;

    logic        Clk = 1'b0;
    logic        Reset_ah;
    logic        Run;
    logic        Continue;
    logic [15:0] IR;
    logic        BEN;
    logic        LD_PC, LD_LED, LD_IR, LD_MAR, LD_MDR, LD_BEN, LD_CC, LD_REG;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        ADDR1MUX, SR1MUX, DRMUX, MIO_EN, Mem_OE, Mem_WE;

    lc3_control_fsm #(
        .MEM_WAIT (MW)
    ) dut (
        .Clk        (Clk),
        .Reset_ah   (Reset_ah),
        .Run        (Run),
        .Continue   (Continue),
        .IR         (IR),
        .BEN        (BEN),
        .LD_PC      (LD_PC),
        .LD_LED     (LD_LED),
        .LD_IR      (LD_IR),
        .LD_MAR     (LD_MAR),
        .LD_MDR     (LD_MDR),
        .LD_BEN     (LD_BEN),
        .LD_CC      (LD_CC),
        .LD_REG     (LD_REG),
        .GatePC     (GatePC),
        .GateMDR    (GateMDR),
        .GateALU    (GateALU),
        .GateMARMUX (GateMARMUX),
        .PCMUX      (PCMUX),
        .ADDR2MUX   (ADDR2MUX),
        .ADDR1MUX   (ADDR1MUX),
        .ALUK       (ALUK),
        .SR1MUX     (SR1MUX),
        .DRMUX      (DRMUX),
        .MIO_EN     (MIO_EN),
        .Mem_OE     (Mem_OE),
        .Mem_WE     (Mem_WE)
    );

    always #5 Clk = ~Clk;

    logic [23:0] obs;
    assign obs = {LD_PC, LD_LED, LD_IR, LD_MAR, LD_MDR, LD_BEN, LD_CC, LD_REG,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ADDR1MUX,
                  ALUK, SR1MUX, DRMUX, MIO_EN, Mem_OE, Mem_WE};

    localparam logic [23:0] B_WE    = 24'h000001;
    localparam logic [23:0] B_OE    = 24'h000002;
    localparam logic [23:0] B_MIO   = 24'h000004;
    localparam logic [23:0] B_DR    = 24'h000008;
    localparam logic [23:0] B_SR1   = 24'h000010;
    localparam logic [23:0] B_A1    = 24'h000080;
    localparam logic [23:0] B_GMAR  = 24'h001000;
    localparam logic [23:0] B_GALU  = 24'h002000;
    localparam logic [23:0] B_GMDR  = 24'h004000;
    localparam logic [23:0] B_GPC   = 24'h008000;
    localparam logic [23:0] B_LDREG = 24'h010000;
    localparam logic [23:0] B_LDCC  = 24'h020000;
    localparam logic [23:0] B_LDBEN = 24'h040000;
    localparam logic [23:0] B_LDMDR = 24'h080000;
    localparam logic [23:0] B_LDMAR = 24'h100000;
    localparam logic [23:0] B_LDIR  = 24'h200000;
    localparam logic [23:0] B_LDLED = 24'h400000;
    localparam logic [23:0] B_LDPC  = 24'h800000;

    function automatic logic [23:0] pcm(input logic [1:0] v);
        return {12'b0, v, 10'b0};
    endfunction
    function automatic logic [23:0] a2(input logic [1:0] v);
        return {14'b0, v, 8'b0};
    endfunction
    function automatic logic [23:0] alu(input logic [1:0] v);
        return {17'b0, v, 5'b0};
    endfunction
    function automatic logic [23:0] w_fetch();
        return B_GPC | B_LDMAR | B_LDPC | pcm(2'd2);
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the cycle-by-cycle control words an instruction should produce,
    // starting with the fetch cycle.
    logic [23:0] exp_q[$];

    task automatic push_read();
        for (int i = 0; i < int'(MW); i++) begin
            exp_q.push_back((i == int'(MW) - 1) ? (B_OE | B_MIO | B_LDMDR) : (B_OE | B_MIO));
        end
    endtask

    task automatic build_expect(input logic [15:0] ir, input logic ben);
        logic [3:0] op;
        op = ir[15:12];
        exp_q.delete();
        exp_q.push_back(w_fetch());
        push_read();
        exp_q.push_back(B_GMDR | B_LDIR);
        exp_q.push_back(B_LDBEN);
        case (op)
            4'b0001: exp_q.push_back(B_SR1 | alu(2'd0) | B_GALU | B_LDREG | B_LDCC);
            4'b0101: exp_q.push_back(B_SR1 | alu(2'd1) | B_GALU | B_LDREG | B_LDCC);
            4'b1001: exp_q.push_back(B_SR1 | alu(2'd2) | B_GALU | B_LDREG | B_LDCC);
            4'b0000: begin
                exp_q.push_back(24'h0);
                if (ben) exp_q.push_back(B_A1 | a2(2'd1) | pcm(2'd1) | B_LDPC);
            end
            4'b1100: exp_q.push_back(B_SR1 | alu(2'd3) | B_GALU | pcm(2'd0) | B_LDPC);
            4'b0100: begin
                exp_q.push_back(B_GPC | B_DR | B_LDREG);
                exp_q.push_back(B_A1 | a2(2'd0) | pcm(2'd1) | B_LDPC);
            end
            4'b0110: begin
                exp_q.push_back(B_SR1 | a2(2'd2) | B_GMAR | B_LDMAR);
                push_read();
                exp_q.push_back(B_GMDR | B_LDREG | B_LDCC);
            end
            4'b0111: begin
                exp_q.push_back(B_SR1 | a2(2'd2) | B_GMAR | B_LDMAR);
                exp_q.push_back(alu(2'd3) | B_GALU | B_LDMDR);
                for (int i = 0; i < int'(MW); i++) exp_q.push_back(B_WE);
            end
            default: ;
        endcase
    endtask

    // Entered at a negedge where the fetch word is already showing; returns at
    // the negedge where the next fetch word shows. len is the cycle count until
    // fetch reappears (0 = take it from the reference sequence).
    task automatic run_instr(input logic [15:0] ir, input logic ben, input int unsigned len,
                             input string name);
        int unsigned n;
        IR  = ir;
        BEN = ben;
        Run = 1'($urandom_range(0, 1));  // must be ignored outside HALTED
        build_expect(ir, ben);
        n = (len == 0) ? exp_q.size() : len;
        for (int unsigned c = 1; c < n; c++) begin
            @(negedge Clk);
            check(name, obs, (c < exp_q.size()) ? exp_q[c] : 24'h0);
        end
        @(negedge Clk);
        check({name, "_return"}, obs, w_fetch());
    endtask

    typedef struct {
        logic [15:0] ir;
        logic        ben;
        int unsigned len;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [15:0] ir, input logic ben, input int unsigned len,
                           input string name);
        vec_t v;
        v.ir   = ir;
        v.ben  = ben;
        v.len  = len;
        v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r_ir;

        // Fetch is 1 + MW + 2 cycles; execute lengths follow each opcode.
        add_vec(16'h1042, 1'b0, 6, "add");
        add_vec(16'h5042, 1'b1, 6, "and");
        add_vec(16'h9FFF, 1'b0, 6, "not");
        add_vec(16'h0E05, 1'b1, 7, "br_taken");
        add_vec(16'h0E05, 1'b0, 6, "br_not_taken");
        add_vec(16'hC1C0, 1'b0, 6, "jmp");
        add_vec(16'h4801, 1'b0, 7, "jsr");
        add_vec(16'h4080, 1'b1, 7, "jsrr_as_jsr");
        add_vec(16'h6442, 1'b0, 9, "ldr");
        add_vec(16'h7442, 1'b0, 9, "str");
        add_vec(16'hF025, 1'b0, 5, "unsupported_f");
        add_vec(16'h2000, 1'b1, 5, "unsupported_2");
        add_vec(16'h8000, 1'b0, 5, "unsupported_8");

        Reset_ah = 1'b1;
        Run      = 1'b0;
        Continue = 1'b0;
        IR       = 16'h0000;
        BEN      = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset_outputs", obs, 24'h0);
        Reset_ah = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            check("halted_idle", obs, 24'h0);
        end
        Run = 1'b1;
        @(negedge Clk);
        check("run_to_fetch", obs, w_fetch());
        Run = 1'b0;

        // Reset in the middle of the fetch read wait.
        IR = 16'h1042;
        @(negedge Clk);
        check("fetch_wait_first", obs, B_OE | B_MIO);
        Reset_ah = 1'b1;
        #1;
        check("async_reset", obs, 24'h0);
        @(negedge Clk);
        check("reset_held", obs, 24'h0);
        Reset_ah = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            check("halted_after_reset", obs, 24'h0);
        end
        Run = 1'b1;
        @(negedge Clk);
        check("rerun_to_fetch", obs, w_fetch());
        Run = 1'b0;

        // Table-driven instruction vectors.
        foreach (vecs[i]) begin
            run_instr(vecs[i].ir, vecs[i].ben, vecs[i].len, vecs[i].name);
        end

        // PAUSE: LED held while Continue low, one instruction per press/release.
        IR  = 16'hD0FF;
        BEN = 1'b0;
        build_expect(16'hD0FF, 1'b0);
        for (int unsigned c = 1; c < exp_q.size(); c++) begin
            @(negedge Clk);
            check("pause_fetch", obs, exp_q[c]);
        end
        repeat (10) begin
            @(negedge Clk);
            check("pause1_led", obs, B_LDLED);
        end
        Continue = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            check("pause2_hold", obs, 24'h0);
        end
        Continue = 1'b0;
        @(negedge Clk);
        check("pause_release", obs, w_fetch());
        run_instr(16'h1042, 1'b0, 0, "after_pause");

        // Continue held high through a PAUSE: single pass to PAUSE2, then wait.
        Continue = 1'b1;
        IR = 16'hD000;
        build_expect(16'hD000, 1'b0);
        for (int unsigned c = 1; c < exp_q.size(); c++) begin
            @(negedge Clk);
            check("pause_cont_fetch", obs, exp_q[c]);
        end
        @(negedge Clk);
        check("pause_cont_led", obs, B_LDLED);
        repeat (4) begin
            @(negedge Clk);
            check("pause_cont_held", obs, 24'h0);
        end
        Continue = 1'b0;
        @(negedge Clk);
        check("pause_cont_release", obs, w_fetch());

        // Randomized instruction stream (PAUSE excluded).
        for (int k = 0; k < 60; k++) begin
            r_ir = 16'($urandom);
            if (r_ir[15:12] == 4'b1101) r_ir[15:12] = 4'b0111;
            run_instr(r_ir, 1'($urandom_range(0, 1)), 0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
